md_unit: RTL and testbench

//  Multi-cycle multiply/divide unit in the E stage. Consumes the RS/RT operands and instruction

---
 rtl/md_if.sv | 14 +
 rtl/md_unit.sv | 133 +++++++++++++
 tb/tb_md_unit.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_if.sv
// Operand/result bus between the D/E pipeline register and the multiply/divide unit.
// start is sampled at a rising clk edge and accepted only while busy is low; HI/LO change only on accepted MTHI/MTLO or at completion.
interface md_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, input busy, HI, LO);
  modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at launch,
// held in pending registers and exposed only when the busy window closes.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus,
  output logic dbg_state
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_wr;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] divisor_u;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] b_abs_safe;
  logic [31:0] q_abs;
  logic [31:0] r_abs;
  logic [31:0] q_s;
  logic [31:0] r_s;

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'b0, bus.A} * {32'b0, bus.B};

  // A zero divisor is replaced by 1 only to keep the datapath defined; its result is never written.
  assign divisor_u = (bus.B == 32'd0) ? 32'd1 : bus.B;
  assign q_u       = bus.A / divisor_u;
  assign r_u       = bus.A % divisor_u;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_abs      = bus.A[31] ? -bus.A : bus.A;
  assign b_abs      = bus.B[31] ? -bus.B : bus.B;
  assign b_abs_safe = (b_abs == 32'd0) ? 32'd1 : b_abs;
  assign q_abs      = a_abs / b_abs_safe;
  assign r_abs      = a_abs % b_abs_safe;
  assign q_s        = (bus.A[31] ^ bus.B[31]) ? -q_abs : q_abs;
  assign r_s        = bus.A[31] ? -r_abs : r_abs;

  assign dbg_state = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      pend_wr  <= 1'b0;
      bus.busy <= 1'b0;
      bus.HI   <= '0;
      bus.LO   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT: begin
                pend_hi  <= prod_s[63:32];
                pend_lo  <= prod_s[31:0];
                pend_wr  <= 1'b1;
                count    <= CW'(MULT_CYCLES);
                state    <= RUN;
                bus.busy <= 1'b1;
              end
              OP_MULTU: begin
                pend_hi  <= prod_u[63:32];
                pend_lo  <= prod_u[31:0];
                pend_wr  <= 1'b1;
                count    <= CW'(MULT_CYCLES);
                state    <= RUN;
                bus.busy <= 1'b1;
              end
              OP_DIV: begin
                pend_hi  <= r_s;
                pend_lo  <= q_s;
                pend_wr  <= (bus.B != 32'd0);
                count    <= CW'(DIV_CYCLES);
                state    <= RUN;
                bus.busy <= 1'b1;
              end
              OP_DIVU: begin
                pend_hi  <= r_u;
                pend_lo  <= q_u;
                pend_wr  <= (bus.B != 32'd0);
                count    <= CW'(DIV_CYCLES);
                state    <= RUN;
                bus.busy <= 1'b1;
              end
              OP_MTHI: bus.HI <= bus.A;
              OP_MTLO: bus.LO <= bus.A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is ignored here, including on the completion edge itself.
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            if (pend_wr) begin
              bus.HI <= pend_hi;
              bus.LO <= pend_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios with literal expectations plus a random phase,
// all checked every cycle against a timestamp-based model of HI/LO/busy.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic rst_n;
  logic dbg_state;

  logic        start_d;
  logic [2:0]  op_d;
  logic [31:0] a_d;
  logic [31:0] b_d;

  int checks;
  int errors;

  md_if bus ();

  assign bus.start = start_d;
  assign bus.op    = op_d;
  assign bus.A     = a_d;
  assign bus.B     = b_d;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each launched op records the edge index at which it completes; busy is
  // simply "current edge index is before that completion index".
  int          edge_n;
  int          done_at;
  logic [31:0] hi_m;
  logic [31:0] lo_m;
  logic [31:0] pend_hi_m;
  logic [31:0] pend_lo_m;
  logic        pend_ok;

  function automatic logic [63:0] m_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  function automatic logic [63:0] m_multu(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = longint'({32'b0, a}) * longint'({32'b0, b});
    return p;
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] m_div(input logic [31:0] a, input logic [31:0] b);
    longint na;
    longint nb;
    longint q;
    longint r;
    na = longint'($signed(a));
    nb = longint'($signed(b));
    q  = na / nb;
    r  = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] m_divu(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n    <= 0;
      done_at   <= 0;
      hi_m      <= '0;
      lo_m      <= '0;
      pend_hi_m <= '0;
      pend_lo_m <= '0;
      pend_ok   <= 1'b0;
    end else begin
      edge_n <= edge_n + 1;
      if (edge_n + 1 <= done_at) begin
        if (edge_n + 1 == done_at && pend_ok) begin
          hi_m <= pend_hi_m;
          lo_m <= pend_lo_m;
        end
      end else if (start_d) begin
        case (op_d)
          3'd1: begin
            {pend_hi_m, pend_lo_m} <= m_mult(a_d, b_d);
            pend_ok <= 1'b1;
            done_at <= edge_n + 1 + MULT_N;
          end
          3'd2: begin
            {pend_hi_m, pend_lo_m} <= m_multu(a_d, b_d);
            pend_ok <= 1'b1;
            done_at <= edge_n + 1 + MULT_N;
          end
          3'd3: begin
            if (b_d != 0) {pend_hi_m, pend_lo_m} <= m_div(a_d, b_d);
            pend_ok <= (b_d != 0);
            done_at <= edge_n + 1 + DIV_N;
          end
          3'd4: begin
            if (b_d != 0) {pend_hi_m, pend_lo_m} <= m_divu(a_d, b_d);
            pend_ok <= (b_d != 0);
            done_at <= edge_n + 1 + DIV_N;
          end
          3'd5: hi_m <= a_d;
          3'd6: lo_m <= a_d;
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'b0, bus.busy}, {31'b0, (edge_n < done_at)});
      chk("state", {31'b0, dbg_state}, {31'b0, (edge_n < done_at)});
      chk("HI", bus.HI, hi_m);
      chk("LO", bus.LO, lo_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    start_d = 1'b1;
    op_d    = op;
    a_d     = a;
    b_d     = b;
    @(negedge clk);
    start_d = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 100) begin
      errors++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected to fall", cyc);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  int cyc;

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start_d = 1'b0;
    op_d    = '0;
    a_d     = '0;
    b_d     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_HI", bus.HI, 32'd0);
    chk("reset_LO", bus.LO, 32'd0);
    rst_n = 1'b1;

    // 1. signed multiply
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, cyc);
    chk("mult_cycles", cyc, MULT_N);
    chk("mult_HI", bus.HI, 32'hFFFF_FFFF);
    chk("mult_LO", bus.LO, 32'hFFFF_FFFA);

    // 2. unsigned multiply
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    chk("multu_cycles", cyc, MULT_N);
    chk("multu_HI", bus.HI, 32'hFFFF_FFFE);
    chk("multu_LO", bus.LO, 32'h0000_0001);

    // 3. divides
    run_op(3'd4, 32'd7, 32'd2, cyc);
    chk("divu_cycles", cyc, DIV_N);
    chk("divu_LO", bus.LO, 32'd3);
    chk("divu_HI", bus.HI, 32'd1);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    chk("div_LO", bus.LO, 32'hFFFF_FFFD);
    chk("div_HI", bus.HI, 32'hFFFF_FFFF);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk("div_ovf_LO", bus.LO, 32'h8000_0000);
    chk("div_ovf_HI", bus.HI, 32'h0000_0000);

    // 4. MTHI/MTLO then divide by zero
    run_op(3'd5, 32'h11, 32'd0, cyc);
    chk("mthi_cycles", cyc, 0);
    chk("mthi_HI", bus.HI, 32'h11);
    run_op(3'd6, 32'h22, 32'd0, cyc);
    chk("mtlo_cycles", cyc, 0);
    chk("mtlo_LO", bus.LO, 32'h22);
    run_op(3'd3, 32'd5, 32'd0, cyc);
    chk("div0_cycles", cyc, DIV_N);
    chk("div0_HI", bus.HI, 32'h11);
    chk("div0_LO", bus.LO, 32'h22);

    // 5. async reset mid-run
    @(negedge clk);
    start_d = 1'b1; op_d = 3'd1; a_d = 32'd1234; b_d = 32'd5678;
    @(negedge clk);
    start_d = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_mid_HI", bus.HI, 32'd0);
    chk("rst_mid_LO", bus.LO, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (MULT_N + 3) @(negedge clk);
    chk("rst_no_late_HI", bus.HI, 32'd0);
    chk("rst_no_late_LO", bus.LO, 32'd0);

    // 6. starts while busy are ignored; back-to-back start after busy falls
    @(negedge clk);
    start_d = 1'b1; op_d = 3'd4; a_d = 32'd100; b_d = 32'd7;
    @(negedge clk);
    op_d = 3'd5; a_d = 32'h55;
    @(negedge clk);
    op_d = 3'd4; a_d = 32'd9; b_d = 32'd2;
    @(negedge clk);
    start_d = 1'b0;
    wait_idle();
    chk("busy_ign_LO", bus.LO, 32'd14);
    chk("busy_ign_HI", bus.HI, 32'd2);
    start_d = 1'b1; op_d = 3'd1; a_d = 32'd6; b_d = 32'd7;
    @(negedge clk);
    start_d = 1'b0;
    chk("b2b_busy", {31'b0, bus.busy}, 32'd1);
    wait_idle();
    chk("b2b_LO", bus.LO, 32'd42);
    chk("b2b_HI", bus.HI, 32'd0);

    // Random phase: starts on any cycle, including while busy and on completion edges.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start_d = ($urandom_range(0, 2) == 0);
      op_d    = 3'($urandom_range(0, 7));
      a_d     = rand_word();
      b_d     = rand_word();
    end
    @(negedge clk);
    start_d = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
